// File: rtl/rx_shifter.sv
// UART receive front-end: 2-flop sync, start qualification, LSB-first deserialiser; rx_valid 1 cycle after last data sample, no backpressure.
// Optional build macro RX_MAJORITY_EN: 2-of-3 majority per data bit and a two-sample start check, with identical timing.
module rx_shifter #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_datain,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 checkstop,
  output logic                 rx_valid,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIDX_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOPW, STOP} state_t;

  state_t               state, state_nxt;
  logic                 sync1, rx_s;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [BW-1:0]        bidx, bidx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 load;
  logic                 armed;
  logic                 bit_val;
  logic                 start_ok;

`ifdef RX_MAJORITY_EN
  localparam logic [CW-1:0] CNT_HALF_PRE = CW'(OVERSAMPLE / 2 - 2);
  localparam logic [CW-1:0] CNT_M3       = CW'(OVERSAMPLE - 3);
  localparam logic [CW-1:0] CNT_M2       = CW'(OVERSAMPLE - 2);
  logic maj_a, maj_b, start_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maj_a    <= 1'b0;
      maj_b    <= 1'b0;
      start_lo <= 1'b0;
    end else begin
      if (state == DATA && cnt == CNT_M3) maj_a <= rx_s;
      if (state == DATA && cnt == CNT_M2) maj_b <= rx_s;
      if (state == START && cnt == CNT_HALF_PRE) start_lo <= ~rx_s;
    end
  end

  assign bit_val  = (maj_a & maj_b) | (maj_a & rx_s) | (maj_b & rx_s);
  assign start_ok = ~rx_s & start_lo;
`else
  assign bit_val  = rx_s;
  assign start_ok = ~rx_s;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    bidx_nxt  = bidx;
    shift_nxt = shift;
    load      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt = '0;
          if (start_ok && armed) begin
            state_nxt = DATA;
            bidx_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          shift_nxt = {bit_val, shift[DATA_BITS-1:1]};
          bidx_nxt  = bidx + 1'b1;
          if (bidx == BIDX_LAST) begin
            load      = 1'b1;
            state_nxt = STOPW;
          end
        end
      end
      STOPW: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // armed: line seen high since the last accepted start. A held-low line (break)
  // keeps it clear, so START keeps aborting instead of assembling phantom bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bidx      <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      checkstop <= 1'b0;
      armed     <= 1'b1;
    end else begin
      sync1     <= rx_datain;
      rx_s      <= sync1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bidx      <= bidx_nxt;
      shift     <= shift_nxt;
      rx_valid  <= load;
      checkstop <= (state_nxt == STOP);
      if (load) rx_data <= shift_nxt;
      if (state == START && state_nxt == DATA) armed <= 1'b0;
      else if (rx_s) armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_shifter.sv
// Directed bench for rx_shifter: stimulus pushes expected bytes, a negedge monitor
// pops them on rx_valid and also checks checkstop placement and width.
module tb_rx_shifter;
  localparam int OS = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_datain = 1'b1;
  logic [7:0] rx_data;
  logic       checkstop, rx_valid, busy;

  rx_shifter #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .rx_datain(rx_datain),
    .rx_data(rx_data), .checkstop(checkstop), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_byte = 8'h00;
  int vld_count = 0;
  int cs_count = 0;
  int vld_cyc = 0;
  int cs_len = 0;
  logic cs_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: scoreboard pop on rx_valid, checkstop window timing and width.
  always @(negedge clk) begin
    if (rx_valid && checkstop) begin
      total_cnt++;
      $display("FAIL valid_cs_overlap: rx_valid and checkstop both high at cycle %0d", cyc);
    end
    if (rx_valid) begin
      vld_count++;
      vld_cyc = cyc;
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_valid: rx_data 0x%0h with empty scoreboard", rx_data);
      end else begin
        last_byte = exp_q.pop_front();
        check("rx_data", int'(rx_data), int'(last_byte));
      end
    end
    if (checkstop && !cs_prev) begin
      cs_count++;
      cs_len = 0;
      check("cs_offset", cyc - vld_cyc, OS / 2);
    end
    if (checkstop) cs_len++;
    if (!checkstop && cs_prev) begin
      check("cs_len", cs_len, OS);
      check("cs_data_hold", int'(rx_data), int'(last_byte));
    end
    cs_prev = checkstop;
  end

  task automatic send_frame(input logic [7:0] b, input bit glitch, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      int   bi;
      int   off;
      logic lvl;
      bi  = i / OS;
      off = i % OS;
      if (bi == 0) lvl = 1'b0;
      else if (bi <= 8) lvl = b[bi-1] | (glitch && off == OS / 2);
      else lvl = 1'b1;
      @(negedge clk);
      rx_datain = lvl;
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_datain = lvl;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int c0;
    logic [7:0] glitch_exp;

    #1;
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_checkstop", int'(checkstop), 0);
    check("reset_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 10);

    // Clean frame 0xA5
    v0 = vld_count; c0 = cs_count;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 80);
    drive(1'b1, 16);
    check("t1_valid_count", vld_count - v0, 1);
    check("t1_cs_count", cs_count - c0, 1);
    check("t1_busy_after", int'(busy), 0);

    // 2-cycle low glitch in idle is a false start
    v0 = vld_count; c0 = cs_count;
    drive(1'b0, 2);
    drive(1'b1, 20);
    check("t2_valid_count", vld_count - v0, 0);
    check("t2_cs_count", cs_count - c0, 0);
    check("t2_busy_after", int'(busy), 0);

    // Back-to-back frames
    v0 = vld_count; c0 = cs_count;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_frame(8'h3C, 1'b0, 80);
    send_frame(8'hC3, 1'b0, 80);
    drive(1'b1, 20);
    check("t3_valid_count", vld_count - v0, 2);
    check("t3_cs_count", cs_count - c0, 2);

    // Async reset during bit 4 of 0xFF
    v0 = vld_count; c0 = cs_count;
    send_frame(8'hFF, 1'b0, 44);
    @(posedge clk);
    #2 rst = 1'b1;
    rx_datain = 1'b1;
    #1;
    check("t4_rst_rx_data", int'(rx_data), 0);
    check("t4_rst_rx_valid", int'(rx_valid), 0);
    check("t4_rst_checkstop", int'(checkstop), 0);
    check("t4_rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 10);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b0, 80);
    drive(1'b1, 16);
    check("t4_valid_count", vld_count - v0, 1);
    check("t4_cs_count", cs_count - c0, 1);

    // Break: line low 12 bit times
    v0 = vld_count; c0 = cs_count;
    exp_q.push_back(8'h00);
    drive(1'b0, 12 * OS);
    drive(1'b1, 40);
    check("t5_break_valid_count", vld_count - v0, 1);
    check("t5_break_cs_count", cs_count - c0, 1);
    check("t5_busy_after_break", int'(busy), 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0, 80);
    drive(1'b1, 16);
    check("t5_valid_count", vld_count - v0, 2);

    // Mid-bit one-cycle high glitches on a 0x00 frame
`ifdef RX_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'hFF;
`endif
    v0 = vld_count;
    exp_q.push_back(glitch_exp);
    send_frame(8'h00, 1'b1, 80);
    drive(1'b1, 16);
    check("t6_valid_count", vld_count - v0, 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
